// File: rtl/rms_pkg.sv
// Shared definitions for the RMS engine front end: engine commands, sample width,
// sequencer state encoding and the engine push payload.
package rms_pkg;

  localparam int unsigned SAMPLE_W       = 32;
  localparam int unsigned ENGINE_CNT_MAX = 1023;

  typedef enum logic [1:0] {
    CMD_ADD          = 2'b00,
    CMD_SUB          = 2'b01,
    CMD_ADD_CALC     = 2'b10,
    CMD_ADD_CALC_CLR = 2'b11
  } cmd_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_POP  = 2'b01,
    S_PUSH = 2'b10
  } seq_state_e;

  // One engine push: command plus its operand sample.
  typedef struct packed {
    cmd_e    cmd;
    sample_t x;
  } eng_req_t;

endpackage

// File: rtl/rms_window_seq_if.sv
// Sample-in handshake and engine push/command bus of the RMS window sequencer.
interface rms_window_seq_if;
  import rms_pkg::*;

  logic       in_valid;
  logic       in_ready;
  sample_t    in_data;
  logic       in_last;
  logic       pushout;
  logic [1:0] cmdout;
  sample_t    Xout;
  logic       win_full;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, pushout, cmdout, Xout, win_full
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, pushout, cmdout, Xout, win_full
  );

endinterface

// File: rtl/rms_hist_ram.sv
// Window history: WIN x 32 register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module rms_hist_ram
  import rms_pkg::*;
#(
  parameter int unsigned WIN = 16,
  parameter int unsigned PW  = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [PW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem [WIN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rms_window_seq.sv
// Sliding-window command sequencer for the RMS engine: turns a sample stream into
// SUB-oldest / ADD-newest pushes over a circular history of WIN samples.
module rms_window_seq
  import rms_pkg::*;
#(
  parameter int unsigned WIN = 16,
  parameter int unsigned PW  = (WIN > 1) ? $clog2(WIN) : 1
) (
  input logic             clk,
  input logic             rst,
  rms_window_seq_if.slave bus
);

  localparam int unsigned   CW        = $clog2(WIN + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(WIN - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIN);
  localparam logic [CW-1:0] CNT_PRE   = CW'(WIN - 1);

  if (WIN == 0 || WIN > ENGINE_CNT_MAX) begin : g_win_check
    $error("rms_window_seq: WIN must be within 1..ENGINE_CNT_MAX");
  end

  seq_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sample_t       sample_q, sample_d;
  logic          last_q, last_d;
  eng_req_t      eng_q, eng_d;
  logic          push_q, push_d;
  logic          ready_q, ready_d;
  logic          full_q, full_d;
  logic          hs;
  logic          wr_en;
  logic [PW-1:0] rd_addr;
  sample_t       rd_data;

  rms_hist_ram #(.WIN(WIN), .PW(PW)) u_hist (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ptr_q),
    .wdata (sample_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign hs      = bus.in_valid && (state_q != S_POP);
  assign rd_addr = ptr_d;

  // Pointer/count update: only a PUSH writes history and advances the window.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (state_q == S_PUSH) begin
      wr_en = 1'b1;
      if (last_q) begin
        ptr_d = '0;
        cnt_d = '0;
      end else begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Next state and next-cycle output decode.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    last_d   = last_q;
    eng_d    = eng_q;

    if (hs) begin
      sample_d = bus.in_data;
      last_d   = bus.in_last;
    end

    case (state_q)
      S_POP:   state_d = S_PUSH;
      default: state_d = hs ? ((cnt_d == CNT_FULL) ? S_POP : S_PUSH) : S_IDLE;
    endcase

    if (state_d == S_PUSH) begin
      eng_d.x = sample_d;
      if (last_d)                                     eng_d.cmd = CMD_ADD_CALC_CLR;
      else if (cnt_d == CNT_PRE || cnt_d == CNT_FULL) eng_d.cmd = CMD_ADD_CALC;
      else                                            eng_d.cmd = CMD_ADD;
    end else if (state_d == S_POP) begin
      eng_d.cmd = CMD_SUB;
      // Oldest slot may be the one being written this cycle (WIN=1).
      eng_d.x   = (wr_en && (ptr_d == ptr_q)) ? sample_q : rd_data;
    end

    push_d  = (state_d != S_IDLE);
    ready_d = (state_d != S_POP);
    full_d  = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      last_q   <= 1'b0;
      eng_q    <= '0;
      push_q   <= 1'b0;
      ready_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      eng_q    <= eng_d;
      push_q   <= push_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.pushout  = push_q;
  assign bus.cmdout   = eng_q.cmd;
  assign bus.Xout     = eng_q.x;
  assign bus.win_full = full_q;

endmodule

// File: tb/tb_rms_window_seq.sv
// Bench for rms_window_seq: cycle tables for WIN=4 and WIN=1, reset during POP,
// and randomized traffic against a queue-based window model.
module tb_rms_window_seq;
  import rms_pkg::*;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        p;
    logic [1:0]  c;
    logic [31:0] x;
    logic        r;
    logic        f;
  } vec_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] x;
  } push_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rms_window_seq_if bus_a ();
  rms_window_seq_if bus_b ();

  rms_window_seq #(.WIN(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rms_window_seq #(.WIN(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        va [13];
  vec_t        vb [11];
  logic [31:0] win_q [$];
  push_t       exp_q [$];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                              input logic p, input logic [1:0] c, input logic [31:0] x,
                              input logic r, input logic f);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.p = p; t.c = c; t.x = x; t.r = r; t.f = f;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Reference window: sliding list of accepted samples since the last block start.
  task automatic model_hs(input logic [31:0] d, input logic l);
    push_t p;
    if (win_q.size() == 4) begin
      p.cmd = CMD_SUB;
      p.x   = win_q.pop_front();
      exp_q.push_back(p);
    end
    win_q.push_back(d);
    p.x   = d;
    p.cmd = l ? CMD_ADD_CALC_CLR : (win_q.size() == 4) ? CMD_ADD_CALC : CMD_ADD;
    exp_q.push_back(p);
    if (l) win_q.delete();
  endtask

  task automatic check_push();
    push_t p;
    if (bus_a.pushout) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rand_spurious_push actual=push expected=none");
      end else begin
        p = exp_q.pop_front();
        chk("rand_cmd", 32'(bus_a.cmdout), 32'(p.cmd));
        chk("rand_x", bus_a.Xout, p.x);
      end
    end
  endtask

  initial begin
    logic [31:0] r, rd;
    logic        rv, rl;
    checks   = 0;
    failures = 0;

    va[0]  = mk(1'b1, 32'd1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    va[1]  = mk(1'b1, 32'd2, 1'b0, 1'b1, 2'd0, 32'd1, 1'b1, 1'b0);
    va[2]  = mk(1'b1, 32'd3, 1'b0, 1'b1, 2'd0, 32'd2, 1'b1, 1'b0);
    va[3]  = mk(1'b1, 32'd4, 1'b0, 1'b1, 2'd0, 32'd3, 1'b1, 1'b0);
    va[4]  = mk(1'b1, 32'd5, 1'b0, 1'b1, 2'd2, 32'd4, 1'b1, 1'b0);
    va[5]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 2'd1, 32'd1, 1'b0, 1'b1);
    va[6]  = mk(1'b1, 32'd6, 1'b0, 1'b1, 2'd2, 32'd5, 1'b1, 1'b1);
    va[7]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 2'd1, 32'd2, 1'b0, 1'b1);
    va[8]  = mk(1'b1, 32'd7, 1'b1, 1'b1, 2'd2, 32'd6, 1'b1, 1'b1);
    va[9]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 2'd1, 32'd3, 1'b0, 1'b1);
    va[10] = mk(1'b1, 32'd9, 1'b0, 1'b1, 2'd3, 32'd7, 1'b1, 1'b1);
    va[11] = mk(1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 32'd9, 1'b1, 1'b0);
    va[12] = mk(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd9, 1'b1, 1'b0);

    vb[0]  = mk(1'b1, -32'sd5, 1'b0, 1'b0, 2'd0, 32'd0,   1'b1, 1'b0);
    vb[1]  = mk(1'b0, 32'd0,   1'b0, 1'b1, 2'd2, -32'sd5, 1'b1, 1'b0);
    vb[2]  = mk(1'b1, 32'd8,   1'b0, 1'b0, 2'd2, -32'sd5, 1'b1, 1'b1);
    vb[3]  = mk(1'b0, 32'd0,   1'b0, 1'b1, 2'd1, -32'sd5, 1'b0, 1'b1);
    vb[4]  = mk(1'b0, 32'd0,   1'b0, 1'b1, 2'd2, 32'd8,   1'b1, 1'b1);
    vb[5]  = mk(1'b1, 32'd3,   1'b0, 1'b0, 2'd2, 32'd8,   1'b1, 1'b1);
    vb[6]  = mk(1'b1, 32'd4,   1'b0, 1'b1, 2'd1, 32'd8,   1'b0, 1'b1);
    vb[7]  = mk(1'b1, 32'd4,   1'b0, 1'b1, 2'd2, 32'd3,   1'b1, 1'b1);
    vb[8]  = mk(1'b0, 32'd0,   1'b0, 1'b1, 2'd1, 32'd3,   1'b0, 1'b1);
    vb[9]  = mk(1'b0, 32'd0,   1'b0, 1'b1, 2'd2, 32'd4,   1'b1, 1'b1);
    vb[10] = mk(1'b0, 32'd0,   1'b0, 1'b0, 2'd2, 32'd4,   1'b1, 1'b1);

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_push",  32'(bus_a.pushout),  32'd0);
    chk("rst_a_cmd",   32'(bus_a.cmdout),   32'd0);
    chk("rst_a_x",     bus_a.Xout,          32'd0);
    chk("rst_a_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rst_a_full",  32'(bus_a.win_full), 32'd0);
    chk("rst_b_push",  32'(bus_b.pushout),  32'd0);
    chk("rst_b_ready", 32'(bus_b.in_ready), 32'd1);

    // WIN=4: fill, slide, close with last, fresh window.
    for (int j = 0; j < 13; j++) begin
      @(posedge clk); #1;
      bus_a.in_valid = va[j].v; bus_a.in_data = va[j].d; bus_a.in_last = va[j].l;
      @(negedge clk);
      chk($sformatf("a%0d_push", j),  32'(bus_a.pushout),  32'(va[j].p));
      chk($sformatf("a%0d_cmd", j),   32'(bus_a.cmdout),   32'(va[j].c));
      chk($sformatf("a%0d_x", j),     bus_a.Xout,          va[j].x);
      chk($sformatf("a%0d_ready", j), 32'(bus_a.in_ready), 32'(va[j].r));
      chk($sformatf("a%0d_full", j),  32'(bus_a.win_full), 32'(va[j].f));
    end

    // WIN=1: first sample CALC, later ones POP+PUSH, including back-to-back.
    for (int j = 0; j < 11; j++) begin
      @(posedge clk); #1;
      bus_b.in_valid = vb[j].v; bus_b.in_data = vb[j].d; bus_b.in_last = vb[j].l;
      @(negedge clk);
      chk($sformatf("b%0d_push", j),  32'(bus_b.pushout),  32'(vb[j].p));
      chk($sformatf("b%0d_cmd", j),   32'(bus_b.cmdout),   32'(vb[j].c));
      chk($sformatf("b%0d_x", j),     bus_b.Xout,          vb[j].x);
      chk($sformatf("b%0d_ready", j), 32'(bus_b.in_ready), 32'(vb[j].r));
      chk($sformatf("b%0d_full", j),  32'(bus_b.win_full), 32'(vb[j].f));
    end

    // Refill WIN=4 to full, then reset in the middle of the POP.
    for (int k = 10; k <= 13; k++) begin
      @(posedge clk); #1;
      bus_a.in_valid = 1'b1; bus_a.in_data = 32'(k); bus_a.in_last = 1'b0;
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("pop_pre_push", 32'(bus_a.pushout), 32'd1);
    chk("pop_pre_cmd",  32'(bus_a.cmdout),  32'(CMD_SUB));
    chk("pop_pre_x",    bus_a.Xout,         32'd9);
    #1 rst = 1'b1;
    #1;
    chk("pop_rst_push",  32'(bus_a.pushout),  32'd0);
    chk("pop_rst_ready", 32'(bus_a.in_ready), 32'd1);
    chk("pop_rst_full",  32'(bus_a.win_full), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'd21;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_push", 32'(bus_a.pushout), 32'd1);
    chk("post_rst_cmd",  32'(bus_a.cmdout),  32'(CMD_ADD));
    chk("post_rst_x",    bus_a.Xout,         32'd21);
    @(negedge clk);
    chk("post_rst_idle", 32'(bus_a.pushout), 32'd0);

    // Random traffic on WIN=4 from a clean reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      r  = $urandom;
      rv = (r[1:0] != 2'd0);
      case (r[4:2])
        3'd0:    rd = 32'h8000_0000;
        3'd1:    rd = 32'h7FFF_FFFF;
        default: rd = $urandom;
      endcase
      rl = (r[9:5] < 5'd3);
      bus_a.in_valid = rv; bus_a.in_data = rd; bus_a.in_last = rl;
      @(negedge clk);
      check_push();
      if (rv && bus_a.in_ready) model_hs(rd, rl);
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_push();
    end
    chk("rand_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rms_window_seq.md
# rms_window_seq

Upstream command sequencer for the RMS engine: accepts a stream of signed 32-bit samples over a valid/ready handshake and turns it into the engine's push/command stream so the engine computes a sliding-window RMS over the last WIN samples. It keeps a circular history of the window, issues a subtract for the oldest sample before adding each new one once the window is full, and requests a result on every full-window sample. Its outputs connect directly to the engine's pushin/cmdin/Xin.

## Interface
- WIN, 16: window length in samples, 1..1023 (the engine's sample counter is 10 bits).
- PW, $clog2(WIN) (min 1): history pointer width.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream sample valid
- in_ready  out  1  sequencer can accept a sample this cycle
- in_data  in  32  signed sample
- in_last  in  1  qualifies in_data as the final sample of a block; closes the window
- pushout  out  1  push strobe to the engine (engine pushin)
- cmdout  out  2  command to the engine (engine cmdin)
- Xout  out  32  signed sample to the engine (engine Xin)
- win_full  out  1  history holds WIN samples

## Operation
- Commands (shared package): CMD_ADD=2'b00, CMD_SUB=2'b01, CMD_ADD_CALC=2'b10, CMD_ADD_CALC_CLR=2'b11.
- State: ptr (PW bits, next write slot; when full, also the oldest slot), count (0..WIN), latched sample, latched last, FSM {IDLE, POP, PUSH}.
- in_ready = (state==IDLE) || (state==PUSH). A handshake is in_valid && in_ready; it latches in_data and in_last.
- Next state on a handshake: POP if the post-PUSH count equals WIN and latched last==0 for a full-window new sample... stated exactly: POP if (count after any PUSH this cycle)==WIN, else PUSH. With no handshake: IDLE.
- POP: pushout=1, cmdout=CMD_SUB, Xout=hist[ptr]. count is unchanged. Next state is always PUSH.
- PUSH: pushout=1 and Xout=latched sample. hist[ptr] is written with the latched sample and ptr advances, wrapping from WIN-1 to 0. count = min(count+1, WIN).
- cmdout in PUSH:
  - CMD_ADD_CALC_CLR if latched last.
  - else CMD_ADD_CALC if the new count==WIN.
  - else CMD_ADD.
- Last handling: in the PUSH with latched last, ptr and count clear to 0 at the end of the cycle. The engine resets its accumulator on the same command.
- IDLE: pushout=0. cmdout and Xout hold their previous values.
- win_full = (count==WIN).
- The downstream engine has no backpressure, so pushout is never stalled.
- Arithmetic: samples pass through unchanged. The sequencer does no arithmetic; sum width is handled in the engine.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from in_* to push/cmd/X outputs. in_ready depends only on state.
- Latency: handshake at edge t produces pushout at cycle t+1 while the window is not full. Once full: CMD_SUB at t+1 and the ADD command at t+2.
- Throughput:
  - 1 sample/cycle while filling.
  - 1 sample/2 cycles when full, because in_ready is low during POP.
- Reset values:
  - state=IDLE, ptr=0, count=0.
  - pushout=0, cmdout=2'b00, Xout=0.
  - win_full=0, in_ready=1.
  - History contents are don't-care.
- Reset mid-operation: an in-flight POP/PUSH is abandoned and no further push is issued. The engine receives the same rst, so both sides restart empty.
- WIN=1:
  - First sample: CMD_ADD_CALC.
  - Every later sample: POP, then PUSH with CMD_ADD_CALC.
- in_last on the very first sample: a single PUSH with CMD_ADD_CALC_CLR; count stays 0.
- A handshake in PUSH with in_last is allowed back-to-back. The next sample starts a fresh window at ptr=0.

## Structure
- rms_pkg: the CMD_* constants, the sample width (32), and the engine counter limit (1023), which is used for a parameter assertion on WIN.
- Sub-module rms_hist_ram: WIN x 32 register array with one write port and one asynchronous read port.
- The FSM, ptr/count, and output registers live in the top module.

## Test plan
- WIN=4, samples 1,2,3,4 back-to-back -> pushes with (cmd,X) = (00,1),(00,2),(00,3),(10,4) on consecutive cycles; win_full=1 after the 4th; in_ready never low.
- Continue with 5,6 -> (01,1),(10,5),(01,2),(10,6); in_ready low in each POP cycle.
- Full window, then 7 with in_last -> (01,3),(10? no) (01,3),(11,7); afterward count=0, win_full=0; next sample 9 -> (00,9).
- WIN=1, samples -5,8 -> (10,-5),(01,-5),(10,8).
- in_valid toggling randomly, including signed extremes 0x80000000 and 0x7FFFFFFF -> every accepted sample appears exactly once as an ADD-type push and once as a SUB after WIN later samples; no push occurs without a prior handshake.
- Assert rst during a POP cycle with WIN=4 full -> pushout=0 immediately; after release in_ready=1, and the next sample gives (00,x).
